// File: rtl/mysystem_seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// scan state encoding, hex-to-segment table and pin polarity helper.
package mysystem_seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Logical (active-high) segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Level a pin rests at when it is not lighting/selecting anything.
  function automatic logic inactive_level(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/mysystem_hex_to_seg7.sv
// Combinational nibble to logical gfedcba decoder (active-high segments).
module mysystem_hex_to_seg7
  import mysystem_seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/mysystem_seg7_scan_ctrl.sv
// 8-digit multiplexed 7-segment scan controller with per-frame snapshot.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading-zero digits.
module mysystem_seg7_scan_ctrl
  import mysystem_seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] disp_data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic SEG_OFF = inactive_level(SEG_ACTIVE_LOW);
  localparam logic DIG_OFF = inactive_level(DIG_ACTIVE_LOW);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("NUM_DIGITS must be in 2..8");
  end
  if (BLANK_CYCLES < 1 || SCAN_DIV <= BLANK_CYCLES) begin : g_bad_timing
    $error("need 1 <= BLANK_CYCLES < SCAN_DIV");
  end

  scan_state_t               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   snap_data_q, snap_data_d;
  logic [NUM_DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]     lz_blank_q, lz_blank_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     dig_sel_q, dig_sel_d;
  logic                      frame_start_q, frame_start_d;

  logic                      capture;
  logic [NUM_DIGITS-1:0]     lz_blank_calc;
  logic [3:0]                cur_nibble;
  logic                      cur_dp;
  logic                      cur_lz;
  logic [NUM_DIGITS-1:0]     dig_onehot;
  logic [6:0]                seg_logical;

  // The frame snapshot is taken at the very first cycle of digit 0's slot,
  // which is always a blanked cycle, so the display never tears.
  assign capture = enable && (idx_q == '0) && (cnt_q == '0);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  genvar gi;
  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    if (gi == 0) begin : g_lsd
      assign lz_blank_calc[gi] = 1'b0;
    end else begin : g_upper
      assign lz_blank_calc[gi] = ~|disp_data[4*NUM_DIGITS-1:4*gi];
    end
  end
`else
  assign lz_blank_calc = '0;
`endif

  always_comb begin
    cnt_d   = '0;
    idx_d   = '0;
    state_d = ST_IDLE;
    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
      end
      // state_q always describes the slot position held in cnt_q/idx_q.
      state_d = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_SHOW;
    end
  end

  always_comb begin
    snap_data_d   = snap_data_q;
    snap_dp_d     = snap_dp_q;
    lz_blank_d    = lz_blank_q;
    frame_start_d = capture;
    if (capture) begin
      snap_data_d = disp_data;
      snap_dp_d   = dp_mask;
      lz_blank_d  = lz_blank_calc;
    end
  end

  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    dig_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nibble    = snap_data_q[4*i +: 4];
        cur_dp        = snap_dp_q[i];
        cur_lz        = lz_blank_q[i];
        dig_onehot[i] = 1'b1;
      end
    end
  end

  mysystem_hex_to_seg7 u_hex_to_seg7 (
    .nibble (cur_nibble),
    .seg    (seg_logical)
  );

  always_comb begin
    seg_d     = {7{SEG_OFF}};
    dp_d      = SEG_OFF;
    dig_sel_d = {NUM_DIGITS{DIG_OFF}};
    if (state_q == ST_SHOW) begin
      dig_sel_d = dig_onehot ^ {NUM_DIGITS{DIG_OFF}};
      seg_d     = cur_lz ? {7{SEG_OFF}} : (seg_logical ^ {7{SEG_OFF}});
      dp_d      = cur_dp ^ SEG_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_data_q   <= '0;
      snap_dp_q     <= '0;
      lz_blank_q    <= '0;
      seg_q         <= {7{SEG_OFF}};
      dp_q          <= SEG_OFF;
      dig_sel_q     <= {NUM_DIGITS{DIG_OFF}};
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_data_q   <= snap_data_d;
      snap_dp_q     <= snap_dp_d;
      lz_blank_q    <= lz_blank_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_sel_q     <= dig_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign dig_sel     = dig_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_mysystem_seg7_scan_ctrl.sv
// Directed bench for mysystem_seg7_scan_ctrl (SCAN_DIV=8, BLANK_CYCLES=2,
// active-low pins); honours SEG7_LEADING_ZERO_BLANK_EN when defined.
module tb_mysystem_seg7_scan_ctrl;

  localparam int ND = 8;
  localparam int SD = 8;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   disp_data;
  logic [7:0]    dp_mask;
  logic          enable;
  logic [6:0]    seg;
  logic          dp;
  logic [7:0]    dig_sel;
  logic          frame_start;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mysystem_seg7_scan_ctrl #(
    .NUM_DIGITS     (ND),
    .SCAN_DIV       (SD),
    .BLANK_CYCLES   (BC),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .disp_data   (disp_data),
    .dp_mask     (dp_mask),
    .enable      (enable),
    .seg         (seg),
    .dp          (dp),
    .dig_sel     (dig_sel),
    .frame_start (frame_start)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Expected pins at frame position k (k=0 is the frame_start cycle).
  task automatic chk_pos(input string tag, input int k, input logic [31:0] data,
                         input logic [7:0] dpm);
    int         d;
    int         c;
    logic       show;
    logic       lz;
    logic [6:0] es;
    logic [7:0] ed;
    logic       edp;
    d    = (k / 8) % 8;
    c    = k % 8;
    show = (c >= BC);
    lz   = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d != 0 && (data >> (4 * d)) == 32'h0) lz = 1'b1;
`endif
    es  = (show && !lz) ? ~hex7(data[4*d +: 4]) : 7'h7F;
    ed  = show ? ~(8'h01 << d) : 8'hFF;
    edp = show ? ~dpm[d] : 1'b1;
    chk($sformatf("%s.seg@%0d", tag, k), {25'd0, seg}, {25'd0, es});
    chk($sformatf("%s.dig@%0d", tag, k), {24'd0, dig_sel}, {24'd0, ed});
    chk($sformatf("%s.dp@%0d", tag, k), {31'd0, dp}, {31'd0, edp});
    chk($sformatf("%s.fs@%0d", tag, k), {31'd0, frame_start}, {31'd0, (k % 64) == 0});
  endtask

  task automatic run_span(input string tag, input int k0, input int k1,
                          input logic [31:0] data, input logic [7:0] dpm);
    for (int k = k0; k <= k1; k++) begin
      chk_pos(tag, k, data, dpm);
      @(negedge clk);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, ".seg"}, {25'd0, seg}, 32'h7F);
    chk({tag, ".dig"}, {24'd0, dig_sel}, 32'hFF);
    chk({tag, ".dp"}, {31'd0, dp}, 32'h1);
    chk({tag, ".fs"}, {31'd0, frame_start}, 32'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    disp_data = 32'h01234567;
    dp_mask   = 8'h00;
    repeat (2) @(negedge clk);
    chk_dark("reset");
    $display("step reset: pins inactive checked");

    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_dark("idle");
    $display("step idle: enable low keeps display dark");

    enable = 1'b1;
    @(negedge clk);
    run_span("f0", 0, 23, 32'h01234567, 8'h00);
    disp_data = 32'hFFFFFFFF;
    dp_mask   = 8'h04;
    run_span("f0_late", 24, 63, 32'h01234567, 8'h00);
    $display("step frame0: 01234567 shown, mid-frame change ignored");

    run_span("f1", 64, 127, 32'hFFFFFFFF, 8'h04);
    $display("step frame1: FFFFFFFF with dp on digit 2");

    run_span("f2", 128, 170, 32'hFFFFFFFF, 8'h04);
    chk_pos("f2", 171, 32'hFFFFFFFF, 8'h04);
    enable    = 1'b0;
    disp_data = 32'h89ABCDEF;
    dp_mask   = 8'h81;
    repeat (2) @(negedge clk);
    chk_dark("disable");
    repeat (3) @(negedge clk);
    chk_dark("disabled");
    $display("step disable: display dark after enable drop in digit 5 show");

    enable = 1'b1;
    @(negedge clk);
    run_span("re", 0, 65, 32'h89ABCDEF, 8'h81);
    chk_pos("re", 66, 32'h89ABCDEF, 8'h81);
    $display("step reenable: digit 0 first, 89ABCDEF decoded");

    #2;
    reset_n = 1'b0;
    #1;
    chk_dark("async_rst");
    $display("step async reset: pins dark before next clock edge");

    disp_data = 32'h00000120;
    dp_mask   = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_span("lz", 0, 59, 32'h00000120, 8'h00);
    disp_data = 32'h00000000;
    run_span("lz_late", 60, 63, 32'h00000120, 8'h00);
    run_span("zero", 64, 127, 32'h00000000, 8'h00);
    $display("step zeros: 00000120 then 00000000 frames");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
